// File: rtl/tt_uo_capture.sv
// Logs every change on a tile's uo_out bus as a {timestamp, value} record
// in a small first-word-fall-through FIFO drained over valid/ready.
module tt_uo_capture #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               uo_in,
  input  logic                     enable,
  input  logic                     clear_ovf,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W+7:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [7:0]      sync1_q, sync2_q, prev_q;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [TS_W+7:0] mem_q [DEPTH];

  logic chg, pop, push, full;

  assign full = (count_q == FULL);
  assign chg  = enable & (sync2_q != prev_q);
  assign pop  = rd_valid & rd_ready;
  assign push = chg & (~full | pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case (1'b1)
      push & ~pop: count_d = count_q + 1'b1;
      pop & ~push: count_d = count_q - 1'b1;
      default:     count_d = count_q;
    endcase
    // a fresh drop in the same cycle beats the clear request
    if (chg & full & ~pop) ovf_d = 1'b1;
    else if (clear_ovf)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= uo_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ts_q    <= ts_q + 1'b1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {ts_q, sync2_q};
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tt_uo_capture.sv
// Bench for tt_uo_capture: queue-based record model plus directed
// literal checks, including a narrow-timestamp instance for wrap.
module tb_tt_uo_capture;

  logic        clk = 1'b0;
  logic        rst, enable, clear_ovf, rd_ready;
  logic [7:0]  uo_in;
  logic        rd_valid, overflow;
  logic [23:0] rd_data;
  logic [3:0]  count;

  logic        rst2, rd_ready2;
  logic [7:0]  u2;
  logic        rd_valid2, overflow2;
  logic [11:0] rd_data2;
  logic [2:0]  count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_uo_capture #(.DEPTH(8), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .uo_in(uo_in), .enable(enable),
    .clear_ovf(clear_ovf), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .overflow(overflow)
  );

  tt_uo_capture #(.DEPTH(4), .TS_W(4)) dut2 (
    .clk(clk), .rst(rst2), .uo_in(u2), .enable(1'b1),
    .clear_ovf(1'b0), .rd_valid(rd_valid2), .rd_ready(rd_ready2),
    .rd_data(rd_data2), .count(count2), .overflow(overflow2)
  );

  // model state: last three uo_in samples, cycle counter, record queue
  logic [7:0]  h1, h2, h3;
  int          mcnt;
  logic [23:0] mq[$];
  logic        movf;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit chg, pop, push, oset;
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0; mcnt = 0; movf = 0;
      mq.delete();
    end else begin
      chg  = enable && (h2 != h3);
      pop  = (mq.size() != 0) && rd_ready;
      push = chg && (mq.size() < 8 || pop);
      oset = chg && mq.size() == 8 && !pop;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({mcnt[15:0], h2});
      if (oset) movf = 1;
      else if (clear_ovf) movf = 0;
      h3 = h2; h2 = h1; h1 = uo_in;
      mcnt++;
    end
    @(posedge clk);
    #1;
    cmp("m_valid", 32'(rd_valid), 32'(mq.size() != 0));
    cmp("m_count", 32'(count), 32'(mq.size()));
    cmp("m_ovf", 32'(overflow), 32'(movf));
    if (mq.size() != 0) cmp("m_data", 32'(rd_data), 32'(mq[0]));
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [15:0] last_ts;
    rst = 1; rst2 = 1; enable = 1; clear_ovf = 0; rd_ready = 0;
    uo_in = 8'h00; u2 = 8'h00; rd_ready2 = 0;
    ticks(2);
    rst = 0; rst2 = 0;
    cmp("rst_valid", 32'(rd_valid), 0);
    cmp("rst_count", 32'(count), 0);
    cmp("rst_ovf", 32'(overflow), 0);
    cmp("rst_data", 32'(rd_data), 0);

    // first change lands before post-reset edge 10
    ticks(9);
    uo_in = 8'hA5;
    ticks(3);
    cmp("a5_valid", 32'(rd_valid), 1);
    cmp("a5_data", 32'(rd_data), 32'h00_000B_A5);
    cmp("a5_count", 32'(count), 1);
    rd_ready = 1;
    tick();
    rd_ready = 0;
    cmp("a5_pop_valid", 32'(rd_valid), 0);
    cmp("a5_pop_count", 32'(count), 0);
    ticks(8);

    // disabled change is never logged, even after re-enable
    enable = 0;
    uo_in = 8'h3C;
    ticks(5);
    enable = 1;
    ticks(5);
    cmp("dis_valid", 32'(rd_valid), 0);

    // nine changes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) begin
      uo_in = 8'(i);
      ticks(3);
    end
    ticks(3);
    cmp("full_count", 32'(count), 8);
    cmp("full_ovf", 32'(overflow), 1);
    rd_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      cmp("drain_val", 32'(rd_data[7:0]), 32'(i));
      if (i > 1) cmp("drain_ts_inc", 32'(rd_data[23:8] > last_ts), 1);
      last_ts = rd_data[23:8];
      tick();
    end
    rd_ready = 0;
    cmp("drained", 32'(count), 0);
    clear_ovf = 1;
    tick();
    clear_ovf = 0;
    cmp("ovf_clr", 32'(overflow), 0);

    // full FIFO accepts a change arriving in its pop cycle
    for (int i = 0; i < 8; i++) begin
      uo_in = 8'(8'h10 + i);
      ticks(2);
    end
    ticks(3);
    cmp("refill", 32'(count), 8);
    uo_in = 8'h18;
    ticks(2);
    rd_ready = 1;
    tick();
    rd_ready = 0;
    cmp("popfull_count", 32'(count), 8);
    cmp("popfull_ovf", 32'(overflow), 0);
    rd_ready = 1;
    ticks(8);
    rd_ready = 0;
    cmp("popfull_drain", 32'(count), 0);

    // reset discards stored entries
    for (int i = 0; i < 5; i++) begin
      uo_in = 8'(8'h40 + i);
      ticks(2);
    end
    ticks(3);
    cmp("pre_rst_count", 32'(count), 5);
    rst = 1;
    tick();
    rst = 0;
    cmp("midrst_count", 32'(count), 0);
    cmp("midrst_valid", 32'(rd_valid), 0);
    cmp("midrst_ovf", 32'(overflow), 0);

    // 4-bit timestamp wrap on the second instance
    rst2 = 1;
    tick();
    rst2 = 0;
    ticks(12);
    u2 = 8'h01;
    ticks(2);
    u2 = 8'h02;
    ticks(2);
    u2 = 8'h03;
    ticks(4);
    cmp("wrap_count", 32'(count2), 3);
    cmp("wrap_r0", 32'(rd_data2), 32'h0E01);
    rd_ready2 = 1;
    tick();
    cmp("wrap_r1", 32'(rd_data2), 32'h0002);
    tick();
    cmp("wrap_r2", 32'(rd_data2), 32'h0203);
    tick();
    rd_ready2 = 0;
    cmp("wrap_empty", 32'(rd_valid2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
